// File: rtl/eth_10g_mac_rx_st_error_adapter_stat_v2.sv
// rtl/eth_10g_mac_rx_st_error_adapter_stat_v2.sv - RX stats error remap, 2-entry skid buffer, optional counters (ERR_ADAPTER_STAT_CNT_EN)
module eth_10g_mac_rx_st_error_adapter_stat_v2 #(
  parameter int DATA_W    = 40,
  parameter int IN_ERR_W  = 5,
  parameter int OUT_ERR_W = 7,
  parameter logic [8*OUT_ERR_W-1:0] ERR_MAP = 56'h00FFFF01040302,
  parameter int CNT_W     = 32,
  parameter int SEL_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [IN_ERR_W-1:0]  in_error,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_ERR_W-1:0] out_error,
  input  logic [SEL_W-1:0]     cnt_sel,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     cnt_value
);

  if ((1 << SEL_W) <= OUT_ERR_W) begin : g_bad_sel
    $error("SEL_W too narrow to address every counter");
  end

  // Remap table: each output error bit picks one source bit or is tied low.
  logic [OUT_ERR_W-1:0] mapped;

  for (genvar gi = 0; gi < OUT_ERR_W; gi++) begin : g_map
    localparam int FIELD = int'(ERR_MAP[8*gi +: 8]);
    if (FIELD < IN_ERR_W) begin : g_src
      assign mapped[gi] = in_error[FIELD];
    end else begin : g_tie
      if (FIELD != 255) begin : g_bad_field
        $error("ERR_MAP field selects a nonexistent in_error bit");
      end
      assign mapped[gi] = 1'b0;
    end
  end

  logic                 main_valid_q, main_valid_d;
  logic [DATA_W-1:0]    main_data_q,  main_data_d;
  logic [OUT_ERR_W-1:0] main_err_q,   main_err_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]    skid_data_q,  skid_data_d;
  logic [OUT_ERR_W-1:0] skid_err_q,   skid_err_d;
  logic                 in_ready_q,   in_ready_d;
  logic                 accept;

  assign accept    = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_error = main_err_q;

  // Skid next state: main refills from skid first so order is preserved.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_err_d   = mapped;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_err_d   = mapped;
    end
    in_ready_d = !skid_valid_d;
  end

  // Datapath registers; reset discards any buffered beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef ERR_ADAPTER_STAT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index OUT_ERR_W is the accepted-beat counter.
  logic [CNT_W-1:0] cnt_q [0:OUT_ERR_W];
  logic [CNT_W-1:0] cnt_d [0:OUT_ERR_W];
  logic [CNT_W-1:0] cnt_value_q, cnt_value_d;

  assign cnt_value = cnt_value_q;

  // Saturating increments; a clear of the same counter overrides its increment.
  always_comb begin
    for (int i = 0; i <= OUT_ERR_W; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (accept) begin
      for (int i = 0; i < OUT_ERR_W; i++) begin
        if (mapped[i] && cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (cnt_q[OUT_ERR_W] != CNT_MAX) begin
        cnt_d[OUT_ERR_W] = cnt_q[OUT_ERR_W] + CNT_W'(1);
      end
    end
    for (int i = 0; i <= OUT_ERR_W; i++) begin
      if (cnt_clear && cnt_sel == SEL_W'(i)) begin
        cnt_d[i] = '0;
      end
    end
    cnt_value_d = '0;
    for (int i = 0; i <= OUT_ERR_W; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_value_d = cnt_q[i];
      end
    end
  end

  // Counter and read-port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= OUT_ERR_W; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_value_q <= '0;
    end else begin
      for (int i = 0; i <= OUT_ERR_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cnt_value_q <= cnt_value_d;
    end
  end
`else
  logic unused_cnt_in;
  assign unused_cnt_in = ^{cnt_sel, cnt_clear};
  assign cnt_value     = '0;
`endif

endmodule

// File: tb/tb_eth_10g_mac_rx_st_error_adapter_stat_v2.sv
// tb/tb_eth_10g_mac_rx_st_error_adapter_stat_v2.sv - scoreboard bench for the RX stats error adapter
module tb_eth_10g_mac_rx_st_error_adapter_stat_v2;

  localparam int DATA_W    = 40;
  localparam int IN_ERR_W  = 5;
  localparam int OUT_ERR_W = 7;
  localparam int CNT_W     = 4;
  localparam int SEL_W     = 4;
  localparam logic [55:0] MAP = 56'h00FFFF01040302;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data = '0;
  logic [IN_ERR_W-1:0]  in_error = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DATA_W-1:0]    out_data;
  logic [OUT_ERR_W-1:0] out_error;
  logic [SEL_W-1:0]     cnt_sel = '0;
  logic                 cnt_clear = 1'b0;
  logic [CNT_W-1:0]     cnt_value;

  eth_10g_mac_rx_st_error_adapter_stat_v2 #(
    .DATA_W(DATA_W), .IN_ERR_W(IN_ERR_W), .OUT_ERR_W(OUT_ERR_W),
    .ERR_MAP(MAP), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]    d;
    logic [OUT_ERR_W-1:0] e;
  } beat_t;

  beat_t  sb[$];
  longint model_cnt [0:OUT_ERR_W];
  longint exp_cnt = 0;
  bit     last_acc = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;

  function automatic logic [OUT_ERR_W-1:0] ref_map(input logic [IN_ERR_W-1:0] e);
    logic [OUT_ERR_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_ERR_W; i++) begin
      int idx;
      idx = int'((MAP >> (8 * i)) & 56'hFF);
      if (idx < IN_ERR_W) r[i] = e[idx];
    end
    return r;
  endfunction

  function automatic longint cnt_exp(input longint v);
`ifdef ERR_ADAPTER_STAT_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records accepted beats and counter effects just before each edge.
  always begin
    @(negedge clk);
    #1;
    if (!reset_n) begin
      last_acc = 1'b0;
      exp_cnt  = 0;
    end else begin
      logic [OUT_ERR_W-1:0] m;
      beat_t b;
      last_acc = in_valid && in_ready;
      exp_cnt  = (cnt_sel <= OUT_ERR_W) ? cnt_exp(model_cnt[cnt_sel]) : 0;
      if (last_acc) begin
        m = ref_map(in_error);
        b.d = in_data;
        b.e = m;
        sb.push_back(b);
        for (int i = 0; i < OUT_ERR_W; i++)
          if (m[i] && model_cnt[i] < CMAX) model_cnt[i]++;
        if (model_cnt[OUT_ERR_W] < CMAX) model_cnt[OUT_ERR_W]++;
      end
      if (cnt_clear && cnt_sel <= OUT_ERR_W) model_cnt[cnt_sel] = 0;
    end
  end

  // Monitor: checks handshake state, read port and pops the scoreboard on each output handshake.
  always begin
    @(negedge clk);
    if (reset_n) begin
      beat_t b;
      chk("cnt_value", cnt_value, exp_cnt);
      chk("in_ready", in_ready, sb.size() < 2);
      chk("out_valid", out_valid, sb.size() > 0);
      if (out_valid && out_ready && sb.size() > 0) begin
        b = sb.pop_front();
        chk("out_data", out_data, b.d);
        chk("out_error", out_error, b.e);
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i <= OUT_ERR_W; i++) model_cnt[i] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    cnt_clear = 1'b0;
    clear_model();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_error", out_error, 0);
    chk("rst_cnt_value", cnt_value, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [IN_ERR_W-1:0] e);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_data  = d;
    in_error = e;
  endtask

  task automatic read_cnt(input int sel, input longint exp, input string name);
    @(posedge clk);
    #2;
    cnt_sel = SEL_W'(sel);
    @(posedge clk);
    @(negedge clk);
    chk(name, cnt_value, cnt_exp(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Single beat latency and remap
    out_ready = 1'b1;
    drive(40'h12_3456_789A, 5'b10101);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 40'h12_3456_789A);
    chk("t1_out_error", out_error, 7'b1000101);

    // Back-to-back stream
    for (int k = 0; k < 8; k++) begin
      drive({8'($urandom), 32'($urandom)}, 5'($urandom));
      @(negedge clk);
      chk("t2_in_ready", in_ready, 1);
      if (k > 0) chk("t2_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_last_valid", out_valid, 1);
    @(negedge clk);
    chk("t2_idle", out_valid, 0);

    // Backpressure fills main and skid, third beat held by source
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 40'hAA_0000_0001;
    in_error  = 5'b00001;
    drive(40'hAA_0000_0002, 5'b00010);
    drive(40'hAA_0000_0003, 5'b00100);
    @(negedge clk);
    chk("t3_in_ready_low", in_ready, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_data", out_data, 40'hAA_0000_0001);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!last_acc && n < 10) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk("t3_third_accepted", last_acc, 1);
      in_valid = 1'b0;
    end
    repeat (4) @(negedge clk);

    // Counters: 10 crc beats
    do_reset();
    cnt_sel = 3;
    for (int k = 0; k < 10; k++) drive({8'($urandom), 32'($urandom)}, 5'b00010);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_crc10", cnt_value, cnt_exp(10));
    read_cnt(7, 10, "t4_beats10");
    read_cnt(0, 0, "t4_undersize0");
    read_cnt(4, 0, "t4_tied0");

    // Saturation and clear-vs-increment
    do_reset();
    for (int k = 0; k < 20; k++) drive({8'($urandom), 32'($urandom)}, 5'b00010);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    read_cnt(3, 15, "t5_crc_sat");
    read_cnt(7, 15, "t5_beat_sat");
    @(posedge clk);
    #2;
    cnt_sel   = 3;
    cnt_clear = 1'b1;
    in_valid  = 1'b1;
    in_error  = 5'b00010;
    @(posedge clk);
    #2;
    cnt_clear = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("t5_preclear", cnt_value, cnt_exp(15));
    @(negedge clk);
    chk("t5_cleared", cnt_value, 0);

    // Reset with both buffer entries full
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 40'hBB_0000_0001;
    in_error  = 5'b11111;
    drive(40'hBB_0000_0002, 5'b11111);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_stale", out_valid, 0);
      chk("t6_ready", in_ready, 1);
    end
    for (int s = 0; s <= OUT_ERR_W; s++) read_cnt(s, 0, "t6_cnt_zero");

    // Randomised traffic with one mid-stream reset
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      @(posedge clk);
      #2;
      if (!(in_valid && !last_acc)) begin
        in_valid = $urandom_range(0, 99) < 60;
        in_data  = {8'($urandom), 32'($urandom)};
        in_error = 5'($urandom);
      end
      out_ready = $urandom_range(0, 99) < 70;
      cnt_sel   = 4'($urandom_range(0, 15));
      cnt_clear = $urandom_range(0, 19) == 0;
    end

    // Drain
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    cnt_clear = 1'b0;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_10g_mac_rx_st_error_adapter_stat_v2.md
Name: eth_10g_mac_rx_st_error_adapter_stat_v2

Overview:
- Parametrised next-generation Avalon-ST error adapter for the 10G MAC RX statistics path. Sits between the MAC RX statistics source and the statistics collector.
- Remaps an arbitrary-width source error vector onto the collector's error vector through a compile-time index table.
- Adds ready/valid backpressure with a 2-entry skid buffer.
- Keeps one saturating event counter per mapped error bit, plus one accepted-beat counter, readable through a select/read port.

Parameters:
- DATA_W, 40, width of in_data/out_data.
- IN_ERR_W, 5, width of in_error.
- OUT_ERR_W, 7, width of out_error (1..16).
- ERR_MAP, 56'h00FFFF01040302, packed OUT_ERR_W x 8-bit fields. Field i (bits 8i+7:8i) is the in_error index driving out_error[i]; 8'hFF ties the bit to 0. Default: 0<-2 undersize, 1<-3 oversize, 2<-4 payload_length, 3<-1 crc, 4/5 tied 0, 6<-0 phy.
- CNT_W, 32, width of each statistics counter.
- SEL_W, 4, width of cnt_sel; must satisfy 2^SEL_W > OUT_ERR_W.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset; deassertion synchronised externally to clk.
- in_valid  in  1  source beat valid.
- in_ready  out  1  adapter can accept a beat.
- in_data  in  DATA_W  statistics payload.
- in_error  in  IN_ERR_W  source error flags.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts a beat.
- out_data  out  DATA_W  payload, unchanged.
- out_error  out  OUT_ERR_W  remapped error flags.
- cnt_sel  in  SEL_W  counter select: 0..OUT_ERR_W-1 selects an error counter; OUT_ERR_W selects the beat counter; larger values read 0.
- cnt_clear  in  1  one-cycle pulse; clears the counter addressed by cnt_sel.
- cnt_value  out  CNT_W  registered value of the selected counter.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_valid=0, in_ready=0, out_data=0, out_error=0, cnt_value=0.
  - Skid buffer emptied; all counters 0.
  - In the first cycle after release, in_ready becomes 1.
- Remap (combinational, applied at input acceptance):
  - mapped[i] = in_error[ERR_MAP field i] when the field value < IN_ERR_W; otherwise 0.
  - A field value >= IN_ERR_W other than 8'hFF is an elaboration error ($error).
- Accept: a beat is accepted when in_valid & in_ready.
- Skid buffer (main register plus skid register, both registered):
  - in_ready is a registered signal, equal to !(skid register occupied).
  - Empty: an accepted beat loads main; out_valid=1 the next cycle. Latency 1 cycle.
  - Main full, out_ready=1: main pops. A simultaneous accept reloads main in the same cycle, sustaining 1 beat/cycle.
  - Main full, out_ready=0, accept: the beat goes to skid; in_ready deasserts the next cycle.
  - Both full, out_ready=1: main takes the skid contents, skid empties, in_ready=1 the next cycle.
  - Order is strictly preserved. No beat is dropped or duplicated. out_data/out_error hold stable while out_valid & !out_ready.
  - in_valid while in_ready=0: the beat is ignored, and the source must hold it.
- Counters:
  - On accept, error counter i increments by 1 if mapped[i]=1.
  - The beat counter increments on every accept.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Counters for tied-0 map fields stay 0.
- Counter read: cnt_value is registered from cnt_sel, 1-cycle latency, and is updated every cycle.
- Clear:
  - cnt_clear zeroes the selected counter at the next edge.
  - Clear coinciding with an increment of the same counter: clear wins, result 0 and the event is lost.
  - Other counters are unaffected.
  - cnt_value in the cycle after a clear reflects the pre-clear value. It shows 0 one cycle later.
- Reset mid-traffic: buffered beats are discarded and counters cleared; no partial output is presented after reset.

Optional Feature:
- Macro: ERR_ADAPTER_STAT_CNT_EN.
- Defined: counters, cnt_clear and cnt_value are implemented as above.
- Undefined: no counter logic is synthesised; cnt_value is tied to 0, and cnt_sel/cnt_clear are ignored. Datapath, remap and skid behaviour are identical.

Test Plan:
- Default map, out_ready=1, single beat with in_error=5'b10101, in_data=40'h12_3456_789A -> one cycle later out_valid=1, out_data=40'h12_3456_789A, out_error=7'b1000101.
- Stream 8 beats back-to-back with out_ready=1 -> 8 outputs on consecutive cycles, in order; in_ready stays 1.
- out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 from the cycle after the 2nd; after out_ready=1 the beats emerge in order and the 3rd is accepted; nothing lost or duplicated.
- 10 beats with in_error=5'b00010, then cnt_sel=3 -> cnt_value=10; cnt_sel=7 -> 10; cnt_sel=0 -> 0; cnt_sel=4 -> 0.
- CNT_W=4, 20 crc beats -> counter 3 reads 15 (saturated); cnt_clear with cnt_sel=3 in the same cycle as a crc accept -> counter reads 0.
- Assert reset_n=0 with both buffer entries full -> out_valid=0 and all counters 0 immediately; after release in_ready=1 and no stale beat appears. Also build without ERR_ADAPTER_STAT_CNT_EN -> cnt_value=0 throughout while the datapath results match.
